// File: rtl/atmos_light_recip_div.sv
// Fixed-point reciprocal unit for the atmospheric-light estimation stage.
// One shared restoring divider computes round(2^FRAC_W / d) for each of
// NUM_CH channel components in turn. Zero operands saturate to all ones
// and raise the matching out_zero flag.
module atmos_light_recip_div #(
  parameter int IN_W   = 8,
  parameter int FRAC_W = 10,
  parameter int NUM_CH = 3,
  parameter int ROUND  = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_CH*IN_W-1:0]        in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_CH*(FRAC_W+1)-1:0]  out_data,
  output logic [NUM_CH-1:0]             out_zero,
  output logic                          busy
);

  localparam int OUT_W = FRAC_W + 1;
  localparam int NUM_W = FRAC_W + 2;
  localparam int CNT_W = $clog2(NUM_W);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, next_state;

  logic [NUM_CH*IN_W-1:0]  ops;
  logic [CH_W-1:0]         ch;
  logic [IN_W:0]           rem;
  logic [NUM_W-1:0]        dvd;
  logic [FRAC_W-1:0]       quo;
  logic [CNT_W-1:0]        cnt;
  logic [NUM_CH*OUT_W-1:0] slot_data, slot_data_nxt;
  logic [NUM_CH-1:0]       slot_zero, slot_zero_nxt;

  logic [IN_W-1:0]  cur_d;
  logic             d_zero;
  logic [NUM_W-1:0] n_val;
  logic [IN_W:0]    rem_shift, rem_nxt;
  logic             ge;
  logic [OUT_W-1:0] q_final, q_out;
  logic             last_step, last_ch;

  // Divider datapath: operand select, dividend build, one restoring step,
  // and the result-slot update that lands on the final step of a channel.
  always_comb begin
    cur_d  = ops[int'(ch)*IN_W +: IN_W];
    d_zero = (cur_d == '0);

    n_val = '0;
    n_val[FRAC_W] = 1'b1;
    if (ROUND != 0) begin
      n_val = n_val + NUM_W'(cur_d >> 1);
    end

    // A set top remainder bit means the shifted value already exceeds any
    // IN_W-bit divisor, so the subtract is taken unconditionally.
    rem_shift = {rem[IN_W-1:0], dvd[NUM_W-1]};
    ge        = rem[IN_W] || (rem_shift >= {1'b0, cur_d});
    rem_nxt   = ge ? (rem_shift - {1'b0, cur_d}) : rem_shift;

    q_final = {quo, ge};
    q_out   = d_zero ? '1 : q_final;

    last_step = (state == DIV) && (cnt == '0);
    last_ch   = (ch == CH_W'(NUM_CH - 1));

    slot_data_nxt = slot_data;
    slot_zero_nxt = slot_zero;
    if (last_step) begin
      slot_data_nxt[int'(ch)*OUT_W +: OUT_W] = q_out;
      slot_zero_nxt[ch] = d_zero;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and handshake outputs, all decoded from the state.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          next_state = LOAD;
        end
      end
      LOAD: begin
        next_state = DIV;
      end
      DIV: begin
        if (cnt == '0) begin
          next_state = last_ch ? DONE : LOAD;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Working registers: operand capture, per-channel divider setup and
  // stepping, and publication of the full result vector after the last channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops       <= '0;
      ch        <= '0;
      rem       <= '0;
      dvd       <= '0;
      quo       <= '0;
      cnt       <= '0;
      slot_data <= '0;
      slot_zero <= '0;
      out_data  <= '0;
      out_zero  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            ops <= in_data;
            ch  <= '0;
          end
        end
        LOAD: begin
          rem <= '0;
          dvd <= n_val;
          quo <= '0;
          cnt <= CNT_W'(NUM_W - 1);
        end
        DIV: begin
          rem       <= rem_nxt;
          dvd       <= {dvd[NUM_W-2:0], 1'b0};
          quo       <= q_final[FRAC_W-1:0];
          cnt       <= cnt - CNT_W'(1);
          slot_data <= slot_data_nxt;
          slot_zero <= slot_zero_nxt;
          if (last_step) begin
            if (last_ch) begin
              out_data <= slot_data_nxt;
              out_zero <= slot_zero_nxt;
            end else begin
              ch <= ch + CH_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
